// File: rtl/ysyx_25040105_ifetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch bus controller.
// Holds the FSM encoding, error codes and the instruction payload struct.
package ysyx_25040105_ifetch_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ERR_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  localparam logic [ERR_W-1:0] INST_ERR_OK       = 2'b00;
  localparam logic [ERR_W-1:0] INST_ERR_MISALIGN = 2'b01;
  localparam logic [ERR_W-1:0] INST_ERR_BUS      = 2'b10;
  localparam logic [1:0]       RRESP_OKAY        = 2'b00;

  typedef struct packed {
    logic [XLEN-1:0]  inst;
    logic [XLEN-1:0]  pc;
    logic [ERR_W-1:0] err;
  } inst_pkt_t;

  // Instructions are word aligned; only the two low PC bits matter.
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

  function automatic logic [ERR_W-1:0] resp_to_err(input logic [1:0] resp);
    return (resp != RRESP_OKAY) ? INST_ERR_BUS : INST_ERR_OK;
  endfunction

endpackage

// File: rtl/ysyx_25040105_sat_cnt.sv
// Enable/clear saturating counter that emits a one-cycle pulse the cycle
// after the count first reaches MAX. MAX of zero disables counting and the pulse.
module ysyx_25040105_sat_cnt #(
  parameter int unsigned     WIDTH = 10,
  parameter logic [WIDTH-1:0] MAX  = '1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic hit
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_d;
  logic             hit_d;

  // Clear has priority; counting stops once MAX is held.
  always_comb begin
    cnt_d = cnt;
    hit_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt != MAX)) begin
      cnt_d = cnt + WIDTH'(1);
      hit_d = (cnt_d == MAX);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      hit <= 1'b0;
    end else begin
      cnt <= cnt_d;
      hit <= hit_d;
    end
  end

endmodule

// File: rtl/ysyx_25040105_ifetch_ctrl.sv
// Instruction-fetch bus controller: one blocking AR/R read per accepted PC,
// result returned to decode via valid/ready, flushed fetches are discarded.
module ysyx_25040105_ifetch_ctrl
  import ysyx_25040105_ifetch_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_valid,
  input  logic [31:0] pc,
  output logic        pc_ready,
  input  logic        flush,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [1:0]  inst_err,
  input  logic        inst_ready,
  output logic        bus_timeout
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  state_e      state_q;
  state_e      state_d;
  logic        drop_q;
  logic        drop_d;
  inst_pkt_t   pkt_q;
  inst_pkt_t   pkt_d;
  logic [31:0] araddr_d;
  logic        in_wait;

  assign inst     = pkt_q.inst;
  assign inst_pc  = pkt_q.pc;
  assign inst_err = pkt_q.err;
  assign in_wait  = (state_q == ST_WAIT);

  // Next state and payload; drop marks a fetch whose data must be thrown away.
  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    pkt_d    = pkt_q;
    araddr_d = araddr;
    case (state_q)
      ST_IDLE: begin
        if (pc_valid && pc_ready) begin
          araddr_d = pc;
          pkt_d.pc = pc;
          if (pc_misaligned(pc[1:0])) begin
            pkt_d.inst = '0;
            pkt_d.err  = INST_ERR_MISALIGN;
            state_d    = ST_RESP;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (flush) drop_d = 1'b1;
        if (arready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (rvalid) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            pkt_d.inst = rdata;
            pkt_d.err  = resp_to_err(rresp);
            state_d    = ST_RESP;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      ST_RESP: begin
        // Flush beats a simultaneous inst_ready; either way the slot is released.
        if (flush || inst_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      drop_q     <= 1'b0;
      pkt_q      <= '0;
      araddr     <= '0;
      pc_ready   <= 1'b1;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      pkt_q      <= pkt_d;
      araddr     <= araddr_d;
      pc_ready   <= (state_d == ST_IDLE);
      arvalid    <= (state_d == ST_REQ);
      rready     <= (state_d == ST_WAIT);
      inst_valid <= (state_d == ST_RESP);
    end
  end

  ysyx_25040105_sat_cnt #(
    .WIDTH (CNT_W),
    .MAX   (CNT_MAX)
  ) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .en  (in_wait),
    .clr (~in_wait),
    .hit (bus_timeout)
  );

endmodule

// File: tb/tb_ysyx_25040105_ifetch_ctrl.sv
// Self-checking bench for the fetch controller: directed scenarios plus
// randomized transactions, each checked slot by slot against protocol rules.
module tb_ysyx_25040105_ifetch_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_valid, pc_ready, flush;
  logic [31:0] pc, araddr, rdata, inst, inst_pc;
  logic        arvalid, arready, rvalid, rready;
  logic        inst_valid, inst_ready, bus_timeout;
  logic [1:0]  rresp, inst_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ysyx_25040105_ifetch_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .pc_ready(pc_ready),
    .flush(flush), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_err(inst_err),
    .inst_ready(inst_ready), .bus_timeout(bus_timeout)
  );

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk_b("rst_pc_ready", pc_ready, 1'b1);
    chk_b("rst_arvalid", arvalid, 1'b0);
    chk_b("rst_rready", rready, 1'b0);
    chk_b("rst_inst_valid", inst_valid, 1'b0);
    chk_b("rst_bus_timeout", bus_timeout, 1'b0);
    chk_w("rst_araddr", araddr, 32'h0);
    chk_w("rst_inst", inst, 32'h0);
    chk_w("rst_inst_pc", inst_pc, 32'h0);
    chk_w("rst_inst_err", 32'(inst_err), 32'h0);
  endtask

  // Normal fetch; rfl >= 0 flushes in that RESP cycle instead of delivering.
  task automatic fetch(input logic [31:0] a, input int ard, input int rd, input int ird,
                       input int rfl, input logic [1:0] resp, input logic [31:0] data);
    logic        mis;
    logic [1:0]  eerr;
    logic [31:0] einst;
    int          waited;
    mis    = (a[1:0] != 2'b00);
    einst  = mis ? 32'h0 : data;
    eerr   = mis ? 2'b01 : ((resp == 2'b00) ? 2'b00 : 2'b10);
    waited = 0;
    chk_b("accept_pc_ready", pc_ready, 1'b1);
    pc_valid = 1'b1;
    pc       = a;
    tick();
    pc_valid = 1'b0;
    pc       = $urandom;
    if (!mis) begin
      for (int i = 0; i <= ard; i++) begin
        chk_b("req_arvalid", arvalid, 1'b1);
        chk_w("req_araddr", araddr, a);
        chk_b("req_rready", rready, 1'b0);
        chk_b("req_inst_valid", inst_valid, 1'b0);
        chk_b("req_pc_ready", pc_ready, 1'b0);
        arready = (i == ard);
        rvalid  = (i < ard) ? 1'($urandom_range(0, 1)) : 1'b0;
        rdata   = $urandom;
        tick();
      end
      arready = 1'b0;
      for (int j = 0; j <= rd; j++) begin
        chk_b("wait_rready", rready, 1'b1);
        chk_b("wait_arvalid", arvalid, 1'b0);
        chk_b("wait_inst_valid", inst_valid, 1'b0);
        chk_b("wait_timeout", bus_timeout, j == TMO);
        rvalid = (j == rd);
        rdata  = (j == rd) ? data : $urandom;
        rresp  = (j == rd) ? resp : 2'($urandom);
        tick();
      end
      rvalid = 1'b0;
      waited = rd + 1;
    end
    for (int k = 0; k <= ird; k++) begin
      chk_b("resp_inst_valid", inst_valid, 1'b1);
      chk_w("resp_inst", inst, einst);
      chk_w("resp_inst_pc", inst_pc, a);
      chk_w("resp_inst_err", 32'(inst_err), 32'(eerr));
      chk_b("resp_arvalid", arvalid, 1'b0);
      chk_b("resp_pc_ready", pc_ready, 1'b0);
      chk_b("resp_timeout", bus_timeout, (k == 0) && (waited == TMO));
      inst_ready = (k == ird);
      flush      = (k == rfl);
      tick();
      if (k == rfl) break;
    end
    inst_ready = 1'b0;
    flush      = 1'b0;
    chk_b("done_inst_valid", inst_valid, 1'b0);
    chk_b("done_pc_ready", pc_ready, 1'b1);
  endtask

  // Fetch squashed by a flush in cycle fsl of the REQ+WAIT window.
  task automatic fetch_drop(input logic [31:0] a, input int ard, input int rd, input int fsl,
                            input logic [31:0] data);
    chk_b("drop_pc_ready", pc_ready, 1'b1);
    pc_valid = 1'b1;
    pc       = a;
    tick();
    pc_valid = 1'b0;
    for (int i = 0; i <= ard; i++) begin
      chk_b("drop_req_arvalid", arvalid, 1'b1);
      chk_w("drop_req_araddr", araddr, a);
      chk_b("drop_req_inst_valid", inst_valid, 1'b0);
      arready = (i == ard);
      flush   = (i == fsl);
      tick();
    end
    arready = 1'b0;
    for (int j = 0; j <= rd; j++) begin
      chk_b("drop_wait_rready", rready, 1'b1);
      chk_b("drop_wait_arvalid", arvalid, 1'b0);
      chk_b("drop_wait_inst_valid", inst_valid, 1'b0);
      chk_b("drop_wait_timeout", bus_timeout, j == TMO);
      rvalid = (j == rd);
      rdata  = data;
      rresp  = 2'($urandom);
      flush  = (ard + 1 + j == fsl);
      tick();
    end
    rvalid = 1'b0;
    flush  = 1'b0;
    chk_b("drop_inst_valid", inst_valid, 1'b0);
    chk_b("drop_pc_ready", pc_ready, 1'b1);
    chk_b("drop_rready", rready, 1'b0);
    chk_b("drop_timeout", bus_timeout, rd + 1 == TMO);
    tick();
    chk_b("drop_later_inst_valid", inst_valid, 1'b0);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      chk_b("idle_pc_ready", pc_ready, 1'b1);
      chk_b("idle_inst_valid", inst_valid, 1'b0);
      chk_b("idle_arvalid", arvalid, 1'b0);
      flush = 1'($urandom_range(0, 1));
      tick();
    end
    flush = 1'b0;
  endtask

  task automatic reset_mid_wait();
    pc_valid = 1'b1;
    pc       = 32'h8000_0020;
    tick();
    pc_valid = 1'b0;
    arready  = 1'b1;
    tick();
    arready = 1'b0;
    for (int j = 0; j <= TMO; j++) begin
      chk_b("rmw_rready", rready, 1'b1);
      chk_b("rmw_timeout", bus_timeout, j == TMO);
      if (j < TMO) tick();
    end
    #2 rst = 1'b0;
    #1 chk_reset_vals();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_b("post_rst_pc_ready", pc_ready, 1'b1);
    chk_b("post_rst_rready", rready, 1'b0);
    chk_b("post_rst_timeout", bus_timeout, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  resp;
    int          kind, ard, rd, ird;
    pc_valid = 1'b0; pc = '0; flush = 1'b0; arready = 1'b0;
    rdata = '0; rresp = '0; rvalid = 1'b0; inst_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    rst = 1'b1;

    fetch(32'h8000_0000, 0, 0, 0, -1, 2'b00, 32'h0000_0413);
    fetch(32'h8000_0002, 0, 0, 0, -1, 2'b00, 32'h1234_5678);
    fetch(32'h8000_0008, 5, 1, 4, -1, 2'b00, 32'h0BAD_C0DE);
    fetch_drop(32'h8000_000C, 1, 2, 3, 32'hDEAD_BEEF);
    fetch(32'h8000_0010, 0, 1, 0, -1, 2'b00, 32'h0050_0093);
    fetch(32'h8000_0004, 0, 0, 0, -1, 2'b10, 32'h0000_0013);
    fetch(32'h8000_0014, 1, 0, 3, 1, 2'b00, 32'h1111_2222);
    fetch(32'h8000_0018, 0, 0, 2, 2, 2'b00, 32'h3333_4444);
    fetch(32'h8000_001C, 0, 20, 0, -1, 2'b00, 32'h5555_6666);
    fetch(32'h8000_0024, 2, TMO - 1, 1, -1, 2'b01, 32'h7777_8888);
    fetch_drop(32'h8000_0028, 0, 3, 0, 32'h9999_AAAA);
    idle_gap(3);

    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 4);
      a    = $urandom;
      d    = $urandom;
      ard  = $urandom_range(0, 3);
      rd   = ($urandom_range(0, 5) == 0) ? $urandom_range(6, 12) : $urandom_range(0, 3);
      ird  = $urandom_range(0, 3);
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (kind == 3 || $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      case (kind)
        0, 1:    fetch(a, ard, rd, ird, -1, resp, d);
        2:       fetch(a, ard, rd, ird, $urandom_range(0, ird), resp, d);
        3:       fetch_drop(a, ard, rd, $urandom_range(0, ard + rd + 1), d);
        default: idle_gap($urandom_range(1, 3));
      endcase
    end

    reset_mid_wait();
    fetch(32'h8000_0030, 0, 0, 0, -1, 2'b00, 32'h00A0_0513);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish before 1ms");
    $fatal(1);
  end

endmodule
